mul_ctrl: RTL and testbench
===========================

Name: mul_ctrl

Overview:
- Control FSM that drives the 3-register datapath (R0/R1/R2, ALU with aop shift/add/pass, lsb status flop).
- Runs an unsigned shift-and-add multiply: R0 = multiplicand, R1 = multiplier, R2 = product.
- The datapath is the executing end; this block issues every Rd/w/sel/Ri/Rj/aop/loadb word and consumes lsb.
- The result is read on the datapath `out` (R2), modulo 2^WIDTH.

Parameters:
- WIDTH, 16, operand and datapath width.
- ITER, 16, number of multiplier bits processed; counter width is clog2(ITER+1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; returns the FSM to IDLE.
- start  input  1  begin a multiply; sampled only in IDLE.
- opa  input  WIDTH  multiplicand; sampled in LDA.
- opb  input  WIDTH  multiplier; sampled in LDB.
- lsb  input  1  datapath lsb flop.
- Rd  output  2  destination register.
- w  output  1  register write enable.
- sel  output  1  1 = write dp_in, 0 = write ALU result.
- Ri  output  2  ALU A-side register select.
- Rj  output  2  ALU B-side register select.
- aop  output  2  ALU op: 00 >>1, 01 <<1, 10 add, 11 pass.
- loadb  output  1  load lsb flop from ALU bit 0.
- dp_in  output  WIDTH  data driven to the datapath `in`.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; product valid on datapath out.

Behaviour:
- Moore outputs decode from state. The single exception: in CHK, w = lsb.
- Unlisted outputs are 0 in every state. Ri/Rj/Rd default to 00; dp_in defaults to 0.
- Reset (async, any state, including mid-operation):
  - state = IDLE, count = 0.
  - All outputs 0: w=0, loadb=0, done=0, busy=0.
  - Datapath registers are not touched by reset; CLR guarantees a clean product.
- IDLE: start=1 -> LDA; otherwise stay.
- LDA: Rd=00, w=1, sel=1, dp_in=opa -> LDB.
- LDB: Rd=01, w=1, sel=1, dp_in=opb -> CLR.
- CLR: Rd=10, w=1, sel=1, dp_in=0; count <= ITER -> TEST.
- TEST: Ri=01, aop=11, loadb=1 (captures R1[0]) -> CHK.
- CHK: Rd=10, Ri=10, Rj=00, aop=10, sel=0, w=lsb (R2 <= R2+R0 when the bit is set) -> SHA.
- SHA: Rd=00, Ri=00, aop=01, sel=0, w=1 (R0 <= R0<<1) -> SHB.
- SHB: Rd=01, Ri=01, aop=00, sel=0, w=1 (R1 <= R1>>1); count <= count-1.
  - Next state is DONE if count-1 == 0, else TEST.
- DONE: done=1, busy=1 -> IDLE.
- Latency: done is high in the cycle 3+4*ITER clock edges after the edge that sampled start. Default: 67.
- Arithmetic: the product wraps modulo 2^WIDTH; there is no overflow flag.
- start while busy: ignored, with no effect on the sequence. start held high in DONE is not sampled until IDLE.
- Back-to-back: start asserted in the IDLE cycle immediately after DONE begins a new multiply.
- ITER=0 is illegal.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined:
  - A WIDTH-bit shadow register loads opb in LDB and shifts right by 1 in SHB.
  - SHB goes to DONE when the shifted shadow == 0 OR count-1 == 0.
  - The product is identical; latency is 3+4*k cycles, where k = max(1, index of the highest set bit of opb + 1).
- Not defined: no shadow register; latency is always 3+4*ITER.

Test Plan:
- opa=3, opb=5, start pulse -> done exactly 67 cycles later; out=15; w asserted in CHK only for iterations 0 and 2.
- opa=0xFFFF, opb=0xFFFF -> out=0x0001 (wrap); busy high continuously from the cycle after start until IDLE.
- opa=0x1234, opb=0 -> out=0; w never asserted in any CHK; done at 67 cycles (at 7 cycles with MUL_EARLY_EXIT_EN).
- Start 6*7; pulse start again at cycle 20 -> ignored; out=42; a single done pulse.
- Start 9*9; assert reset at cycle 30 for 1 cycle -> busy=0, all outputs 0 immediately (async); then 2*3 -> out=6, no residue from the aborted run.
- MUL_EARLY_EXIT_EN, opa=10, opb=4 -> out=40, done 15 cycles after start (k=3); back-to-back start in the following IDLE also yields the correct result.

Source files
------------

// File: rtl/mul_ctrl.sv
// mul_ctrl: shift-and-add multiply sequencer for the R0/R1/R2 datapath.
// Optional MUL_EARLY_EXIT_EN stops once the remaining multiplier bits are all zero.
module mul_ctrl #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             lsb,
  output logic [1:0]       Rd,
  output logic             w,
  output logic             sel,
  output logic [1:0]       Ri,
  output logic [1:0]       Rj,
  output logic [1:0]       aop,
  output logic             loadb,
  output logic [WIDTH-1:0] dp_in,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(ITER + 1);
  localparam logic [3:0] IDLE = 4'd0, LDA = 4'd1, LDB = 4'd2, CLR = 4'd3, TEST = 4'd4,
                         CHK = 4'd5, SHA = 4'd6, SHB = 4'd7, DONE = 4'd8;
  logic [3:0]    state, nxt;
  logic [CW-1:0] count;
  logic          last;
`ifdef MUL_EARLY_EXIT_EN
  logic [WIDTH-1:0] shadow;
  always_ff @(posedge clk or posedge reset)
    if (reset) shadow <= '0;
    else if (state == LDB) shadow <= opb;
    else if (state == SHB) shadow <= shadow >> 1;
  assign last = count == CW'(1) || (shadow >> 1) == '0;
`else
  assign last = count == CW'(1);
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LDA : IDLE;
      LDA:     nxt = LDB;
      LDB:     nxt = CLR;
      CLR:     nxt = TEST;
      TEST:    nxt = CHK;
      CHK:     nxt = SHA;
      SHA:     nxt = SHB;
      SHB:     nxt = last ? DONE : TEST;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= nxt;
      if (state == CLR) count <= CW'(ITER);
      else if (state == SHB) count <= count - CW'(1);
    end
  // the add in CHK only commits when the captured multiplier bit is set
  assign w     = (state inside {LDA, LDB, CLR, SHA, SHB}) | (state == CHK & lsb);
  assign sel   = state inside {LDA, LDB, CLR};
  assign Rd    = (state == LDB || state == SHB) ? 2'd1 : (state == CLR || state == CHK) ? 2'd2 : 2'd0;
  assign Ri    = (state == TEST || state == SHB) ? 2'd1 : state == CHK ? 2'd2 : 2'd0;
  assign Rj    = 2'd0;
  assign aop   = state == TEST ? 2'b11 : state == CHK ? 2'b10 : state == SHA ? 2'b01 : 2'b00;
  assign loadb = state == TEST;
  assign dp_in = state == LDA ? opa : state == LDB ? opb : '0;
  assign busy  = state != IDLE;
  assign done  = state == DONE;
endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: drives mul_ctrl against a behavioural datapath and checks products, latency and control timing.
module tb_mul_ctrl;
  logic        clk = 0, reset = 1, start = 0, lsb = 0;
  logic [15:0] opa = 0, opb = 0, dp_in;
  logic [1:0]  Rd, Ri, Rj, aop;
  logic        w, sel, loadb, busy, done;
  logic [15:0] r [3];
  int n_cmp = 0, n_bad = 0;

  mul_ctrl dut (.clk(clk), .reset(reset), .start(start), .opa(opa), .opb(opb), .lsb(lsb),
                .Rd(Rd), .w(w), .sel(sel), .Ri(Ri), .Rj(Rj), .aop(aop), .loadb(loadb),
                .dp_in(dp_in), .busy(busy), .done(done));

  always #5 clk = ~clk;

  function automatic logic [15:0] alu(input logic [1:0] op, input logic [15:0] a, b);
    return op == 2'b00 ? a >> 1 : op == 2'b01 ? a << 1 : op == 2'b10 ? a + b : a;
  endfunction

  // datapath the controller steers; not reset, CLR is responsible for a clean product
  always @(posedge clk) begin
    logic [15:0] y;
    y = alu(aop, r[Ri], r[Rj]);
    if (w && Rd < 2'd3) r[Rd] <= sel ? dp_in : y;
    if (loadb) lsb <= y[0];
  end

  function automatic int exp_lat(input logic [15:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int k = 1;
    for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
    return 3 + 4 * k;
`else
    return 3 + 4 * 16;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk(nm, {busy, done, w, loadb, sel, Rd, Ri, Rj, aop, dp_in}, 0);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] p, input int glitch);
    int e = 0, it = 0;
    logic [15:0] mask = 0;
    logic busy_ok = 1;
    opa = a; opb = b; start = 1;
    @(negedge clk);
    start = 0;
    while (!done && e < 200) begin
      busy_ok &= busy;
      if (aop == 2'b10 && it < 16) begin
        mask[it] = w;
        it++;
      end
      start = (e == glitch);
      @(negedge clk);
      e++;
    end
    start = 0;
    chk("latency", e, exp_lat(b));
    chk("busy_run", {busy_ok, busy}, 2'b11);
    chk("product", r[2], p);
    chk("chk_w_mask", mask, b);
    @(negedge clk);
    chk("idle_after_done", {busy, done}, 0);
  endtask

  typedef struct { logic [15:0] a, b, p; int glitch; } vec_t;
  vec_t tbl [6];

  initial begin
    tbl[0] = '{16'd3, 16'd5, 16'd15, -1};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 16'h0001, -1};
    tbl[2] = '{16'h1234, 16'h0000, 16'h0000, -1};
    tbl[3] = '{16'd6, 16'd7, 16'd42, 20};
    tbl[4] = '{16'd10, 16'd4, 16'd40, -1};
    tbl[5] = '{16'd10, 16'd4, 16'd40, -1};
    r[0] = 16'hAAAA; r[1] = 16'h5555; r[2] = 16'hDEAD;
    @(negedge clk);
    chk_quiet("reset_outputs");
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk_quiet("idle_outputs");
    for (int i = 0; i < 6; i++) run(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].glitch);
    // abort mid-run: outputs must clear without waiting for a clock edge
    opa = 9; opb = 9; start = 1;
    @(negedge clk);
    start = 0;
    repeat (30) @(negedge clk);
    chk("busy_before_abort", busy, 1);
    reset = 1;
    #1;
    chk_quiet("async_reset");
    @(negedge clk);
    reset = 0;
    run(16'd2, 16'd3, 16'd6, -1);
    for (int i = 0; i < 20; i++) begin
      logic [15:0] a, b, p;
      a = 16'($urandom);
      b = (i % 4 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      p = 16'(32'(a) * 32'(b));
      run(a, b, p, (i % 3 == 0) ? int'($urandom_range(0, 40)) : -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
